// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit: MULT/MULTU/DIV/DIVU over WIDTH+1 cycles.
// Results go to the architectural HI/LO registers. The unit stalls the front end while it works.
module ex_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_opb;
  logic             r_is_div;
  logic             r_neg_a;
  logic             r_neg_b;

  logic             w_signed;
  logic             w_rs_neg;
  logic             w_rt_neg;
  logic [WIDTH-1:0] w_rs_mag;
  logic [WIDTH-1:0] w_rt_mag;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_trial;
  logic [W2-1:0]    w_mul_next;
  logic [W2-1:0]    w_div_next;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  assign w_signed = ~op[0];
  assign w_rs_neg = w_signed & rs_val[WIDTH-1];
  assign w_rt_neg = w_signed & rt_val[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? WIDTH'(0) - rs_val : rs_val;
  assign w_rt_mag = w_rt_neg ? WIDTH'(0) - rt_val : rt_val;

  // Multiply: acc = {partial, multiplier}; add multiplicand on lsb, then shift right with carry.
  assign w_add      = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : (WIDTH+1)'(0));
  assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

  // Restoring divide: acc = {remainder, dividend/quotient}, one quotient bit per step.
  assign w_trial    = r_acc[W2-1:WIDTH-1] - {1'b0, r_opb};
  assign w_div_next = w_trial[WIDTH] ? {r_acc[W2-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign correction; a zero divisor leaves the dividend in the remainder half.
  assign w_prod = (r_neg_a ^ r_neg_b) ? W2'(0) - r_acc : r_acc;
  assign w_quo  = (r_opb == '0) ? '1
                : (r_neg_a ^ r_neg_b) ? WIDTH'(0) - r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_a ? WIDTH'(0) - r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];

  assign stall_req = ((r_state == IDLE) & start & ~flush) | (r_state == CALC);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start && !flush) begin
            r_state  <= CALC;
            busy     <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_neg_a  <= w_rs_neg;
            r_neg_b  <= w_rt_neg;
            r_opb    <= op[1] ? w_rt_mag : w_rs_mag;
            r_acc    <= {WIDTH'(0), (op[1] ? w_rs_mag : w_rt_mag)};
          end
        end
        CALC: begin
          if (flush) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) r_state <= FIN;
          end
        end
        FIN: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (r_is_div) begin
              hi <= w_rem;
              lo <= w_quo;
            end else begin
              hi <= w_prod[W2-1:WIDTH];
              lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed table, flush/reset/back-to-back sequences,
// and random operations against an arithmetic reference model.
module tb_ex_muldiv;

  localparam int unsigned WIDTH = 32;

  logic             CLK;
  logic             nRST;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             stall_req;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int nvec = 0;
  int nerr = 0;

  ex_muldiv #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .stall_req(stall_req), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero, % follows the dividend.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (o)
      2'd0: res = 64'(sa * sb);
      2'd1: res = ua * ub;
      2'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return res;
  endfunction

  // Issue one op, scramble operands after the start edge, wait for done.
  // lat = edges after the start edge until done is seen; nstall = stall-high cycles after it.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int nstall);
    lat = -1;
    nstall = 0;
    @(negedge CLK);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    #1;
    chk("stall_on_start", 64'(stall_req), 64'd1);
    @(posedge CLK); #1;
    start = 1'b0; op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
    for (int k = 1; k <= 100; k++) begin
      if (stall_req) nstall++;
      @(posedge CLK); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  vec_t        tbl[9];
  int          lat, nst, ndone, first_d, second_d;
  logic [1:0]  ro;
  logic [31:0] ra, rb;
  logic [63:0] exp_r;

  initial begin
    tbl[0] = '{2'd1, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE};
    tbl[1] = '{2'd0, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    tbl[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    tbl[3] = '{2'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[4] = '{2'd3, 32'h7,         32'h2,         32'h1,         32'h3};
    tbl[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    tbl[6] = '{2'd3, 32'h5,         32'h0,         32'h5,         32'hFFFF_FFFF};
    tbl[7] = '{2'd2, 32'h5,         32'h0,         32'h5,         32'hFFFF_FFFF};
    tbl[8] = '{2'd2, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

    nRST = 1'b0; start = 1'b0; op = '0; rs_val = '0; rt_val = '0; flush = 1'b0;
    #12;
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_stall", 64'(stall_req), 64'd0);
    @(negedge CLK); nRST = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, nst);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(WIDTH + 1));
      chk($sformatf("tbl%0d_stall_cycles", i), 64'(nst), 64'(WIDTH));
      chk($sformatf("tbl%0d_hi", i), 64'(hi), 64'(tbl[i].ehi));
      chk($sformatf("tbl%0d_lo", i), 64'(lo), 64'(tbl[i].elo));
      @(posedge CLK); #1;
      chk($sformatf("tbl%0d_done_pulse", i), 64'(done), 64'd0);
    end

    // Flush mid-CALC keeps the preloaded HI/LO
    run_op(2'd1, 32'd3, 32'd4, lat, nst);
    chk("preload_hilo", {hi, lo}, 64'h0000_0000_0000_000C);
    @(negedge CLK);
    start = 1'b1; op = 2'd0; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (9) @(posedge CLK);
    #1; flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hilo", {hi, lo}, 64'h0000_0000_0000_000C);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (done) ndone++;
    end
    chk("flush_no_done", 64'(ndone), 64'd0);
    run_op(2'd3, 32'd7, 32'd2, lat, nst);
    chk("after_flush_latency", 64'(lat), 64'(WIDTH + 1));
    chk("after_flush_hilo", {hi, lo}, 64'h0000_0001_0000_0003);

    // Flush beats start in IDLE
    @(negedge CLK);
    start = 1'b1; flush = 1'b1; op = 2'd1;
    #1;
    chk("flush_start_stall", 64'(stall_req), 64'd0);
    @(posedge CLK); #1;
    chk("flush_start_busy", 64'(busy), 64'd0);
    start = 1'b0; flush = 1'b0;

    // start held high: one done per op, ops WIDTH+2 cycles apart
    @(negedge CLK);
    start = 1'b1; op = 2'd1; rs_val = 32'd3; rt_val = 32'd4;
    ndone = 0; first_d = -1; second_d = -1;
    for (int k = 0; k <= 110; k++) begin
      @(posedge CLK); #1;
      if (done) begin
        ndone++;
        if (first_d < 0) first_d = k;
        else if (second_d < 0) second_d = k;
      end
    end
    start = 1'b0;
    chk("held_done_count", 64'(ndone), 64'd3);
    chk("held_first_done", 64'(first_d), 64'(WIDTH + 1));
    chk("held_spacing", 64'(second_d - first_d), 64'(WIDTH + 2));
    repeat (40) @(posedge CLK);

    // Random operations against the model
    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      exp_r = model(ro, ra, rb);
      run_op(ro, ra, rb, lat, nst);
      chk($sformatf("rand%0d_op%0d_%h_%h_latency", i, ro, ra, rb), 64'(lat), 64'(WIDTH + 1));
      chk($sformatf("rand%0d_op%0d_%h_%h_hilo", i, ro, ra, rb), {hi, lo}, exp_r);
    end

    // Asynchronous reset mid-CALC
    run_op(2'd1, 32'hFFFF_FFFF, 32'h2, lat, nst);
    @(negedge CLK);
    start = 1'b1; op = 2'd0; rs_val = 32'h1234_5678; rt_val = 32'h9;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #2; nRST = 1'b0;
    #1;
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_stall", 64'(stall_req), 64'd0);
    @(negedge CLK); nRST = 1'b1;
    run_op(2'd3, 32'd7, 32'd2, lat, nst);
    chk("post_arst_hilo", {hi, lo}, 64'h0000_0001_0000_0003);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
